// File: rtl/sap1_microsequencer.sv
// SAP-1 control sequencer: one-hot T1..T6 ring counter, opcode decode into
// the 12-bit control word, run/single-step gating, HLT latch, bus-source
// select for the top-level bus mux and a retired-instruction counter.
module sap1_microsequencer #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111,
  parameter int         CNT_W  = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [3:0]       opcode,
  input  logic             run,
  input  logic             step,
  output logic [11:0]      con_word,
  output logic [5:0]       bus_sel,
  output logic [5:0]       t_state,
  output logic             halted,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  // Control word bit order: {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo}.
  // CE (bit 8) and Ei (bit 6) are active-low, so idle keeps both high.
  localparam logic [11:0] CW_IDLE   = 12'h140;
  localparam logic [11:0] CW_T1     = 12'h740;  // Ep, Lm
  localparam logic [11:0] CW_T2     = 12'h940;  // Cp
  localparam logic [11:0] CW_T3     = 12'h0C0;  // CE, Li
  localparam logic [11:0] CW_IR_MAR = 12'h300;  // Ei, Lm
  localparam logic [11:0] CW_RAM_A  = 12'h060;  // CE, La
  localparam logic [11:0] CW_RAM_B  = 12'h042;  // CE, Lb
  localparam logic [11:0] CW_ADD    = 12'h164;  // Eu, La
  localparam logic [11:0] CW_SUB    = 12'h16C;  // Su, Eu, La
  localparam logic [11:0] CW_OUT    = 12'h151;  // Ea, Lo

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_t;

  ring_t ring;
  logic  adv;
  logic  hlt_end;
  logic  is_alu_op;

  assign adv        = ~halted & (run | step);
  assign hlt_end    = (ring == T4) && (opcode == OP_HLT);
  assign is_alu_op  = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign instr_done = adv & ((ring == T6) | hlt_end);
  assign t_state    = ring;

  // Ring advance, HLT latch and retired-instruction count; all frozen while stalled.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      ring        <= T1;
      halted      <= 1'b0;
      instr_count <= '0;
    end else if (adv) begin
      if (instr_done) instr_count <= instr_count + CNT_W'(1);
      if (hlt_end) begin
        halted <= 1'b1;
      end else begin
        case (ring)
          T1:      ring <= T2;
          T2:      ring <= T3;
          T3:      ring <= T4;
          T4:      ring <= T5;
          T5:      ring <= T6;
          T6:      ring <= T1;
          default: ring <= T1;
        endcase
      end
    end
  end

  // Control word decode; forced idle when not advancing so nothing loads or counts.
  always_comb begin
    con_word = CW_IDLE;
    if (adv) begin
      case (ring)
        T1: con_word = CW_T1;
        T2: con_word = CW_T2;
        T3: con_word = CW_T3;
        T4: begin
          if ((opcode == OP_LDA) || is_alu_op) con_word = CW_IR_MAR;
          else if (opcode == OP_OUT)           con_word = CW_OUT;
        end
        T5: begin
          if (opcode == OP_LDA) con_word = CW_RAM_A;
          else if (is_alu_op)   con_word = CW_RAM_B;
        end
        T6: begin
          if (opcode == OP_ADD)      con_word = CW_ADD;
          else if (opcode == OP_SUB) con_word = CW_SUB;
        end
        default: con_word = CW_IDLE;
      endcase
    end
  end

  // Bus driver select {PC, RAM, ACC, ALU, IR, none}, priority IR > ALU > ACC > RAM > PC.
  always_comb begin
    bus_sel = 6'b000001;
    if (!con_word[6])      bus_sel = 6'b000010;
    else if (con_word[2])  bus_sel = 6'b000100;
    else if (con_word[4])  bus_sel = 6'b001000;
    else if (!con_word[8]) bus_sel = 6'b010000;
    else if (con_word[10]) bus_sel = 6'b100000;
  end

endmodule

// File: tb/tb_sap1_microsequencer.sv
// Self-checking bench for sap1_microsequencer: an 8-bit-counter instance and a
// 2-bit-counter instance share stimulus and are compared against a model that
// tracks the T-step number, halt flag and retired count as plain integers.
module tb_sap1_microsequencer;

  localparam logic [3:0] LDA = 4'b0000;
  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] OUTP = 4'b1110;
  localparam logic [3:0] HLT = 4'b1111;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        run = 1'b0;
  logic        step = 1'b0;

  logic [11:0] con_word, con_word_w;
  logic [5:0]  bus_sel, bus_sel_w, t_state, t_state_w;
  logic        halted, halted_w, instr_done, instr_done_w;
  logic [7:0]  instr_count;
  logic [1:0]  instr_count_w;

  int total = 0;
  int bad = 0;

  // Reference model state
  int m_t = 1;
  bit m_halt = 1'b0;
  int m_cnt = 0;

  sap1_microsequencer dut (
    .CLK(CLK), .CLR(CLR), .opcode(opcode), .run(run), .step(step),
    .con_word(con_word), .bus_sel(bus_sel), .t_state(t_state),
    .halted(halted), .instr_done(instr_done), .instr_count(instr_count)
  );

  sap1_microsequencer #(.CNT_W(2)) dut_w (
    .CLK(CLK), .CLR(CLR), .opcode(opcode), .run(run), .step(step),
    .con_word(con_word_w), .bus_sel(bus_sel_w), .t_state(t_state_w),
    .halted(halted_w), .instr_done(instr_done_w), .instr_count(instr_count_w)
  );

  always #5 CLK = ~CLK;

  logic [61:0] act_vec;
  assign act_vec = {con_word, bus_sel, t_state, halted, instr_done, instr_count,
                    con_word_w, bus_sel_w, t_state_w, halted_w, instr_done_w, instr_count_w};

  function automatic bit m_adv();
    return !m_halt && (run || step);
  endfunction

  // Control word table straight from the instruction definitions.
  function automatic logic [11:0] exp_cw(int t, logic [3:0] op, bit a);
    if (!a) return 12'h140;
    if (t == 1) return 12'h740;
    if (t == 2) return 12'h940;
    if (t == 3) return 12'h0C0;
    case (op)
      LDA:  return (t == 4) ? 12'h300 : (t == 5) ? 12'h060 : 12'h140;
      ADD:  return (t == 4) ? 12'h300 : (t == 5) ? 12'h042 : 12'h164;
      SUB:  return (t == 4) ? 12'h300 : (t == 5) ? 12'h042 : 12'h16C;
      OUTP: return (t == 4) ? 12'h151 : 12'h140;
      default: return 12'h140;
    endcase
  endfunction

  function automatic logic [5:0] exp_bus(logic [11:0] cw);
    if (cw[6] == 1'b0) return 6'b000010;  // IR
    if (cw[2])         return 6'b000100;  // ALU
    if (cw[4])         return 6'b001000;  // ACC
    if (cw[8] == 1'b0) return 6'b010000;  // RAM
    if (cw[10])        return 6'b100000;  // PC
    return 6'b000001;
  endfunction

  function automatic logic [61:0] model_vec();
    logic [11:0] cw;
    logic [5:0]  ts;
    logic        done;
    logic [25:0] e;
    cw   = exp_cw(m_t, opcode, m_adv());
    ts   = 6'(1 << (m_t - 1));
    done = m_adv() && (m_t == 6 || (m_t == 4 && opcode == HLT));
    e    = {cw, exp_bus(cw), ts, m_halt, done};
    return {e, 8'(m_cnt), e, 2'(m_cnt)};
  endfunction

  task automatic set_inputs(input bit r, input bit s, input logic [3:0] op);
    @(negedge CLK);
    run = r;
    step = s;
    opcode = op;
    #1;
  endtask

  // Clock edge: advance the model with the inputs that were present at the edge.
  task automatic edge_update();
    @(posedge CLK);
    if (m_adv()) begin
      if (m_t == 4 && opcode == HLT) begin
        m_halt = 1'b1;
        m_cnt++;
      end else if (m_t == 6) begin
        m_t = 1;
        m_cnt++;
      end else begin
        m_t++;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    CLR = 1'b0;
    run = 1'b0;
    step = 1'b0;
    m_t = 1;
    m_halt = 1'b0;
    m_cnt = 0;
    @(negedge CLK);
    CLR = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    CLR = 1'b0;
    run = 1'b1;
    m_t = 1; m_halt = 1'b0; m_cnt = 0;
    run = 1'b0;
    #1;
    total++;
    if (act_vec !== model_vec()) begin
      bad++;
      $display("FAIL reset_asserted: got %h want %h", act_vec, model_vec());
    end
    @(negedge CLK);
    CLR = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_inputs(1'b0, 1'b0, $urandom % 16);
      total++;
      if ({t_state, con_word, halted, instr_count} !== {6'h01, 12'h140, 1'b0, 8'd0}) begin
        bad++;
        $display("FAIL reset_hold cyc%0d: got %h/%h/%b/%0d want 01/140/0/0",
                 i, t_state, con_word, halted, instr_count);
      end
      edge_update();
    end
  endtask

  task automatic test_lda();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      set_inputs(1'b1, $urandom % 2, LDA);
      total++;
      if (act_vec !== model_vec()) begin
        bad++;
        $display("FAIL lda cyc%0d: got %h want %h", i, act_vec, model_vec());
      end
      edge_update();
    end
    set_inputs(1'b0, 1'b0, LDA);
    total++;
    if (instr_count !== 8'd2) begin
      bad++;
      $display("FAIL lda_count: got %0d want 2", instr_count);
    end
  endtask

  task automatic test_sub();
    apply_reset();
    for (int i = 0; i < 18; i++) begin
      set_inputs(1'b1, 1'b0, SUB);
      total++;
      if (act_vec !== model_vec()) begin
        bad++;
        $display("FAIL sub cyc%0d: got %h want %h", i, act_vec, model_vec());
      end
      if (i % 6 == 5) begin
        total++;
        if ({con_word, bus_sel} !== {12'h16C, 6'b000100}) begin
          bad++;
          $display("FAIL sub_t6 cyc%0d: got %h/%b want 16c/000100", i, con_word, bus_sel);
        end
      end
      edge_update();
    end
  endtask

  task automatic test_step();
    apply_reset();
    for (int p = 0; p < 14; p++) begin
      set_inputs(1'b0, 1'b1, ADD);
      total++;
      if (act_vec !== model_vec()) begin
        bad++;
        $display("FAIL step_pulse p%0d: got %h want %h", p, act_vec, model_vec());
      end
      edge_update();
      for (int k = 0; k < 3; k++) begin
        set_inputs(1'b0, 1'b0, ADD);
        total++;
        if (act_vec !== model_vec() || con_word !== 12'h140) begin
          bad++;
          $display("FAIL step_idle p%0d k%0d: got %h want %h", p, k, act_vec, model_vec());
        end
        edge_update();
      end
    end
  endtask

  task automatic test_hlt();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      set_inputs(1'b1, 1'b0, HLT);
      total++;
      if (act_vec !== model_vec()) begin
        bad++;
        $display("FAIL hlt_run cyc%0d: got %h want %h", i, act_vec, model_vec());
      end
      edge_update();
    end
    for (int i = 0; i < 20; i++) begin
      set_inputs($urandom % 2, $urandom % 2, $urandom % 16);
      total++;
      if ({halted, instr_count, con_word, t_state} !== {1'b1, 8'd1, 12'h140, 6'b001000}
          || act_vec !== model_vec()) begin
        bad++;
        $display("FAIL hlt_stay cyc%0d: got %b/%0d/%h/%b want 1/1/140/001000",
                 i, halted, instr_count, con_word, t_state);
      end
      edge_update();
    end
    apply_reset();
    set_inputs(1'b0, 1'b0, LDA);
    total++;
    if ({halted, instr_count} !== {1'b0, 8'd0}) begin
      bad++;
      $display("FAIL hlt_clear: got %b/%0d want 0/0", halted, instr_count);
    end
    edge_update();
  endtask

  task automatic test_wrap();
    logic [1:0] want [5];
    want = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    apply_reset();
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 6; i++) begin
        set_inputs(1'b1, 1'b0, LDA);
        total++;
        if (act_vec !== model_vec()) begin
          bad++;
          $display("FAIL wrap_seq n%0d cyc%0d: got %h want %h", n, i, act_vec, model_vec());
        end
        edge_update();
      end
      set_inputs(1'b0, 1'b0, LDA);
      total++;
      if (instr_count_w !== want[n] || instr_count !== 8'(n + 1)) begin
        bad++;
        $display("FAIL wrap_count n%0d: got %0d/%0d want %0d/%0d",
                 n, instr_count_w, instr_count, want[n], n + 1);
      end
      edge_update();
    end
    // Walk into T5 of the next instruction, then pull CLR between clock edges.
    for (int i = 0; i < 4; i++) begin
      set_inputs(1'b1, 1'b0, LDA);
      edge_update();
    end
    @(negedge CLK);
    run = 1'b0;
    #1;
    total++;
    if (t_state !== 6'b010000) begin
      bad++;
      $display("FAIL wrap_pre_t5: got %b want 010000", t_state);
    end
    CLR = 1'b0;
    #1;
    total++;
    if ({t_state, instr_count, instr_count_w} !== {6'b000001, 8'd0, 2'd0}) begin
      bad++;
      $display("FAIL async_clr: got %b/%0d/%0d want 000001/0/0", t_state, instr_count, instr_count_w);
    end
    m_t = 1; m_halt = 1'b0; m_cnt = 0;
    @(negedge CLK);
    CLR = 1'b1;
  endtask

  task automatic test_random();
    logic [3:0] op;
    op = LDA;
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      if (m_halt && ($urandom % 6 == 0)) apply_reset();
      if (m_t == 1) op = 4'($urandom % 16);
      set_inputs(($urandom % 3) != 0, $urandom % 2, op);
      total++;
      if (act_vec !== model_vec()) begin
        bad++;
        $display("FAIL random cyc%0d: got %h want %h", i, act_vec, model_vec());
      end
      edge_update();
    end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_sub();
    test_step();
    test_hlt();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sap1_microsequencer.md
Name: sap1_microsequencer

Overview:
- Control sequencer for the SAP-1 datapath (PC, MAR, RAM, IR, accumulator, B register, ALU, output register).
- A one-hot ring counter steps T1..T6 and decodes the IR opcode into the 12-bit control word {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo}.
- Adds run/single-step gating, HLT handling, a one-hot bus-source select for the top-level bus mux, and a retired-instruction counter.

Parameters:
- OP_LDA, 4'b0000, load-accumulator opcode
- OP_ADD, 4'b0001, add opcode
- OP_SUB, 4'b0010, subtract opcode
- OP_OUT, 4'b1110, output opcode
- OP_HLT, 4'b1111, halt opcode
- CNT_W, 8, width of the retired-instruction counter

Ports:
- CLK  in  1  system clock; all state changes on the rising edge
- CLR  in  1  asynchronous, active-low reset
- opcode  in  4  IR[7:4], valid from T4 onward
- run  in  1  level; 1 = free-run, advance every cycle
- step  in  1  single-cycle pulse; advances one T-state while run=0
- con_word  out  12  control word; CE and Ei active-low, all other bits active-high
- bus_sel  out  6  one-hot bus driver select {PC, RAM, ACC, ALU, IR, none}, bit5..bit0
- t_state  out  6  one-hot ring state, bit0 = T1
- halted  out  1  1 after HLT has been decoded
- instr_done  out  1  high during the final advancing cycle of each instruction
- instr_count  out  CNT_W  number of retired instructions

Behaviour:
- Reset (CLR=0, asynchronous):
  - t_state=6'b000001, halted=0, instr_count=0.
  - con_word=12'h140 (idle), bus_sel=6'b000001.
- adv = ~halted & (run | step). When run=1, step is ignored.
- On a rising edge with adv=1, t_state rotates T1→T2→…→T6→T1. On an edge with adv=0, state holds.
- con_word is combinational (Moore on t_state plus opcode) and gated: when adv=0 it is forced to idle 12'h140, so no register loads and no PC increment occur while stalled.
- Control words when adv=1:
  - Fetch:
    - T1 = 12'h740 (Ep, Lm)
    - T2 = 12'h940 (Cp)
    - T3 = 12'h0C0 (CE=0, Li)
  - LDA:
    - T4 = 12'h300 (Ei=0, Lm)
    - T5 = 12'h060 (CE=0, La)
    - T6 = 12'h140
  - ADD:
    - T4 = 12'h300
    - T5 = 12'h042 (CE=0, Lb)
    - T6 = 12'h164 (Eu, La)
  - SUB: as ADD except T6 = 12'h16C (Su, Eu, La).
  - OUT:
    - T4 = 12'h151 (Ea, Lo)
    - T5 = 12'h140
    - T6 = 12'h140
  - HLT: T4 = 12'h140; the rising edge ending T4 sets halted=1, and t_state holds at T4.
  - Undefined opcodes execute as NOP (T4..T6 = 12'h140).
- bus_sel is derived from con_word with priority IR (Ei=0) > ALU (Eu) > ACC (Ea) > RAM (CE=0) > PC (Ep) > none. It is exactly one-hot at all times.
- instr_done:
  - high in T6 when adv=1, and in HLT's T4 when adv=1;
  - instr_count increments on that edge and wraps from 2^CNT_W-1 to 0.
- Halted state:
  - adv=0, so con_word is idle and run and step are ignored.
  - The only exit is CLR. HLT counts as one retired instruction.
- Reset asserted mid-instruction aborts it immediately with no partial count. The datapath is resumed from T1 after reset.
- run falling mid-instruction: the sequence freezes at the current T-state and continues correctly on later steps.

Test Plan:
- CLR=0 then released, run=0, no step → t_state=6'h01, con_word=12'h140, halted=0, instr_count=0, held for 10 cycles.
- run=1, opcode=LDA → con_word sequence 740, 940, 0C0, 300, 060, 140 repeating; instr_done pulses every 6th cycle; instr_count=2 after 12 cycles.
- run=1, opcode=SUB → T5=12'h042 with bus_sel=RAM, T6=12'h16C with bus_sel=ALU; instr_count increments once per 6 cycles.
- run=0, with step pulses separated by 3 idle cycles, opcode=ADD → exactly one T-state advance per pulse; con_word=12'h140 on all idle cycles; no double Cp.
- run=1, opcode=HLT → after T4, halted=1 and count=1. con_word stays 12'h140 for 20 further cycles despite step pulses. CLR clears halted.
- Counter wrap: CNT_W=2, run LDA for 5 instructions → instr_count = 1, 2, 3, 0, 1. Additionally, assert CLR during T5 → t_state=T1 and instr_count=0 asynchronously.
